// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline encodings for the MEM->WB stage
package mips_pkg;

    // Write-back data source select
    localparam logic [2:0] WDSEL_ALU = 3'b000;
    localparam logic [2:0] WDSEL_DM  = 3'b001;
    localparam logic [2:0] WDSEL_PC8 = 3'b010;

    // Load width / extension type
    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    // Exception codes reported at retire
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic {
        ST_RUN,
        ST_TRAP
    } state_t;

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - byte/half extraction and sign/zero extension of a DM read word
module load_ext
    import mips_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rd,
    input  logic [1:0]    addr,
    input  logic [2:0]    ld_type,
    output logic [DW-1:0] word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half (little-endian lanes) and extend it to a full word
    always_comb begin
        case (addr)
            2'd0:    byte_sel = rd[7:0];
            2'd1:    byte_sel = rd[15:8];
            2'd2:    byte_sel = rd[23:16];
            default: byte_sel = rd[31:24];
        endcase
        half_sel = addr[1] ? rd[31:16] : rd[15:0];
        case (ld_type)
            LD_LB:   word = {{(DW-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  word = {{(DW-8){1'b0}}, byte_sel};
            LD_LH:   word = {{(DW-16){half_sel[15]}}, half_sel};
            LD_LHU:  word = {{(DW-16){1'b0}}, half_sel};
            default: word = rd;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM->WB pipeline register with write-back select and trap FSM (optional MEM_WB_TRACE_EN)
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Stall,
    input  logic          Flush,
    input  logic          ExcClr,
    input  logic          M_Valid,
    input  logic [DW-1:0] M_PC,
    input  logic [2:0]    M_WDsel,
    input  logic [2:0]    M_LdType,
    input  logic [DW-1:0] M_A,
    input  logic [DW-1:0] M_RD,
    input  logic [DW-1:0] M_ALU,
    input  logic [AW-1:0] M_A3,
    input  logic          M_RegWr,
    input  logic          M_AdEl,
    input  logic          M_AdEs,
    output logic          W_Valid,
    output logic [DW-1:0] W_PC,
    output logic [AW-1:0] W_A3,
    output logic [DW-1:0] W_WD,
    output logic          W_RegWr,
    output logic          W_Exc,
    output logic [4:0]    W_ExcCode,
    output logic          Trap
);

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] ld_word;
    logic [DW-1:0] wd;
    logic          run;
    logic          exc;
    logic [4:0]    exc_code;
    logic          regwr_d;
    logic          unused_addr;

    // Only the byte lane bits of the DM address matter in this stage
    assign unused_addr = ^M_A[DW-1:2];

    load_ext #(.DW(DW)) u_load_ext (
        .rd      (M_RD),
        .addr    (M_A[1:0]),
        .ld_type (M_LdType),
        .word    (ld_word)
    );

    // Write-back value, exception decode and GRF write qualification
    always_comb begin
        case (M_WDsel)
            WDSEL_DM:  wd = ld_word;
            WDSEL_PC8: wd = M_PC + DW'(8);
            default:   wd = M_ALU;
        endcase
        run      = (state == ST_RUN);
        exc      = M_Valid & (M_AdEl | M_AdEs);
        exc_code = M_AdEl ? EXC_ADEL : EXC_ADES;
        regwr_d  = M_RegWr & M_Valid & ~exc & (M_A3 != '0) & run;
    end

    // Trap FSM next state: a flush still lets ExcClr act, a plain stall freezes it
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:  if (!Flush && !Stall && exc) state_next = ST_TRAP;
            ST_TRAP: if (ExcClr && (Flush || !Stall)) state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    // Trap FSM state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= ST_RUN;
        else        state <= state_next;
    end

    // Stage registers: flush inserts a bubble, stall holds, TRAP squashes retirement
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            W_Valid   <= 1'b0;
            W_PC      <= '0;
            W_A3      <= '0;
            W_WD      <= '0;
            W_RegWr   <= 1'b0;
            W_Exc     <= 1'b0;
            W_ExcCode <= EXC_NONE;
        end else if (Flush) begin
            W_Valid   <= 1'b0;
            W_PC      <= '0;
            W_A3      <= '0;
            W_WD      <= '0;
            W_RegWr   <= 1'b0;
            W_Exc     <= 1'b0;
            W_ExcCode <= EXC_NONE;
        end else if (!Stall) begin
            W_Valid   <= M_Valid & run;
            W_PC      <= M_PC;
            W_A3      <= M_A3;
            W_WD      <= wd;
            W_RegWr   <= regwr_d;
            W_Exc     <= exc & run;
            W_ExcCode <= (exc & run) ? exc_code : EXC_NONE;
        end
    end

    assign Trap = (state == ST_TRAP);

`ifdef MEM_WB_TRACE_EN
    // Log every GRF write as it is committed into the W stage
    always @(posedge Clk) begin
        if (Reset && !Flush && !Stall && regwr_d)
            $display("@%h: $%d <= %h", M_PC, M_A3, wd);
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        Clk = 1'b0;
    logic        Reset, Stall, Flush, ExcClr;
    logic        M_Valid, M_RegWr, M_AdEl, M_AdEs;
    logic [31:0] M_PC, M_A, M_RD, M_ALU;
    logic [2:0]  M_WDsel, M_LdType;
    logic [4:0]  M_A3;
    logic        W_Valid, W_RegWr, W_Exc, Trap;
    logic [31:0] W_PC, W_WD;
    logic [4:0]  W_A3, W_ExcCode;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    mem_wb_stage #(.DW(32), .AW(5)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .ExcClr(ExcClr),
        .M_Valid(M_Valid), .M_PC(M_PC), .M_WDsel(M_WDsel), .M_LdType(M_LdType),
        .M_A(M_A), .M_RD(M_RD), .M_ALU(M_ALU), .M_A3(M_A3), .M_RegWr(M_RegWr),
        .M_AdEl(M_AdEl), .M_AdEs(M_AdEs),
        .W_Valid(W_Valid), .W_PC(W_PC), .W_A3(W_A3), .W_WD(W_WD), .W_RegWr(W_RegWr),
        .W_Exc(W_Exc), .W_ExcCode(W_ExcCode), .Trap(Trap)
    );

    typedef struct {
        logic        excclr, valid;
        logic [31:0] pc;
        logic [2:0]  wdsel, ldtype;
        logic [31:0] a, rd, alu;
        logic [4:0]  a3;
        logic        regwr, adel, ades;
        logic        e_valid, e_regwr, e_exc;
        logic [4:0]  e_code;
        logic        e_trap;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic excclr, input logic valid, input logic [31:0] pc,
                       input logic [2:0] wdsel, input logic [2:0] ldtype, input logic [31:0] a,
                       input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] a3,
                       input logic regwr, input logic adel, input logic ades,
                       input logic e_valid, input logic e_regwr, input logic e_exc,
                       input logic [4:0] e_code, input logic e_trap, input logic [31:0] e_wd);
        vec_t v;
        v.excclr = excclr; v.valid = valid; v.pc = pc; v.wdsel = wdsel; v.ldtype = ldtype;
        v.a = a; v.rd = rd; v.alu = alu; v.a3 = a3; v.regwr = regwr; v.adel = adel; v.ades = ades;
        v.e_valid = e_valid; v.e_regwr = e_regwr; v.e_exc = e_exc; v.e_code = e_code;
        v.e_trap = e_trap; v.e_wd = e_wd;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic valid, input logic [31:0] pc, input logic [2:0] wdsel,
                         input logic [2:0] ldtype, input logic [31:0] a, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] a3, input logic regwr,
                         input logic adel, input logic ades);
        M_Valid = valid; M_PC = pc; M_WDsel = wdsel; M_LdType = ldtype; M_A = a;
        M_RD = rd; M_ALU = alu; M_A3 = a3; M_RegWr = regwr; M_AdEl = adel; M_AdEs = ades;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
    endtask

    // Reference load extension from the lane arithmetic
    function automatic logic [31:0] ref_ext(input logic [2:0] ldtype, input logic [31:0] a,
                                            input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'((rd >> (8 * a[1:0])) & 32'hFF);
        h = 16'((rd >> (16 * a[1])) & 32'hFFFF);
        case (ldtype)
            3'd1:    return 32'($signed(b));
            3'd2:    return {24'd0, b};
            3'd3:    return 32'($signed(h));
            3'd4:    return {16'd0, h};
            default: return rd;
        endcase
    endfunction

    // Reference model state
    logic        m_trap, e_valid, e_regwr, e_exc;
    logic [4:0]  e_code, e_a3;
    logic [31:0] e_pc, e_wd;

    localparam logic [31:0] RD0 = 32'h80FF_7F01;

    initial begin
        Stall = 0; Flush = 0; ExcClr = 0;
        drive(1, 32'h100, 3'd1, 3'd1, 32'h3, RD0, 32'h0, 5'd8, 1, 0, 0);
        Reset = 1'b0;
        #1;
        chk("rst_valid", 32'(W_Valid), 0);
        chk("rst_regwr", 32'(W_RegWr), 0);
        chk("rst_exc", 32'(W_Exc), 0);
        chk("rst_code", 32'(W_ExcCode), 0);
        chk("rst_trap", 32'(Trap), 0);
        chk("rst_wd", W_WD, 0);
        chk("rst_pc", W_PC, 0);
        tick();
        Reset = 1'b1;

        // excclr valid pc wdsel ldtype a rd alu a3 regwr adel ades | valid regwr exc code trap wd
        add(0,1,32'h100,3'd1,3'd1,32'h3,RD0,0,5'd8,1,0,0, 1,1,0,0,0,32'hFFFF_FF80);
        add(0,1,32'h104,3'd1,3'd4,32'h2,RD0,0,5'd8,1,0,0, 1,1,0,0,0,32'h0000_80FF);
        add(0,1,32'h108,3'd1,3'd3,32'h0,RD0,0,5'd8,1,0,0, 1,1,0,0,0,32'h0000_7F01);
        add(0,1,32'h10C,3'd1,3'd1,32'h1,RD0,0,5'd8,1,0,0, 1,1,0,0,0,32'h0000_007F);
        add(0,1,32'h110,3'd1,3'd2,32'h3,RD0,0,5'd8,1,0,0, 1,1,0,0,0,32'h0000_0080);
        add(0,1,32'h114,3'd1,3'd1,32'h2,RD0,0,5'd8,1,0,0, 1,1,0,0,0,32'hFFFF_FFFF);
        add(0,1,32'h118,3'd1,3'd3,32'h2,RD0,0,5'd8,1,0,0, 1,1,0,0,0,32'hFFFF_80FF);
        add(0,1,32'h11C,3'd1,3'd0,32'h0,RD0,0,5'd8,1,0,0, 1,1,0,0,0,32'h80FF_7F01);
        add(0,1,32'h120,3'd1,3'd5,32'h1,RD0,0,5'd8,1,0,0, 1,1,0,0,0,32'h80FF_7F01);
        add(0,1,32'h3000,3'd2,3'd0,0,0,0,5'd31,1,0,0, 1,1,0,0,0,32'h0000_3008);
        add(0,1,32'h3000,3'd2,3'd0,0,0,0,5'd0,1,0,0, 1,0,0,0,0,32'h0);
        add(0,1,32'h124,3'd0,3'd0,0,0,32'hDEAD_BEEF,5'd5,1,0,0, 1,1,0,0,0,32'hDEAD_BEEF);
        add(0,1,32'h128,3'd3,3'd0,0,RD0,32'h1234_5678,5'd5,1,0,0, 1,1,0,0,0,32'h1234_5678);
        add(0,1,32'hFFFF_FFFC,3'd2,3'd0,0,0,0,5'd31,1,0,0, 1,1,0,0,0,32'h0000_0004);
        add(0,0,32'h12C,3'd0,3'd0,0,0,1,5'd7,1,0,0, 0,0,0,0,0,32'h0);
        add(0,1,32'h130,3'd0,3'd0,0,0,1,5'd7,0,0,0, 1,0,0,0,0,32'h0);
        add(0,1,32'h3010,3'd1,3'd0,0,RD0,0,5'd9,1,1,1, 1,0,1,5'd4,1,32'h0);
        add(0,1,32'h3014,3'd1,3'd0,0,RD0,0,5'd9,1,0,0, 0,0,0,0,1,32'h0);
        add(0,1,32'h3018,3'd1,3'd0,0,RD0,0,5'd9,1,0,0, 0,0,0,0,1,32'h0);
        add(0,1,32'h301C,3'd1,3'd0,0,RD0,0,5'd9,1,0,0, 0,0,0,0,1,32'h0);
        add(1,1,32'h3020,3'd1,3'd0,0,RD0,0,5'd9,1,0,0, 0,0,0,0,0,32'h0);
        add(0,1,32'h3024,3'd1,3'd0,0,32'h1234,0,5'd10,1,0,0, 1,1,0,0,0,32'h0000_1234);
        add(0,1,32'h3028,3'd1,3'd0,0,0,0,5'd10,1,0,1, 1,0,1,5'd5,1,32'h0);
        add(1,1,32'h302C,3'd1,3'd0,0,0,0,5'd10,1,1,0, 0,0,0,0,0,32'h0);
        add(0,1,32'h3030,3'd0,3'd0,0,0,32'h55,5'd11,1,0,0, 1,1,0,0,0,32'h0000_0055);
        add(0,0,32'h3034,3'd0,3'd0,0,0,0,5'd11,1,1,0, 0,0,0,0,0,32'h0);
        add(0,1,32'h3038,3'd0,3'd0,0,0,0,5'd11,1,1,0, 1,0,1,5'd4,1,32'h0);
        add(1,0,32'h303C,3'd0,3'd0,0,0,0,5'd11,0,0,0, 0,0,0,0,0,32'h0);

        foreach (vecs[i]) begin
            ExcClr = vecs[i].excclr;
            drive(vecs[i].valid, vecs[i].pc, vecs[i].wdsel, vecs[i].ldtype, vecs[i].a,
                  vecs[i].rd, vecs[i].alu, vecs[i].a3, vecs[i].regwr, vecs[i].adel, vecs[i].ades);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(W_Valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_regwr", i), 32'(W_RegWr), 32'(vecs[i].e_regwr));
            chk($sformatf("v%0d_exc", i), 32'(W_Exc), 32'(vecs[i].e_exc));
            chk($sformatf("v%0d_code", i), 32'(W_ExcCode), 32'(vecs[i].e_code));
            chk($sformatf("v%0d_trap", i), 32'(Trap), 32'(vecs[i].e_trap));
            if (vecs[i].e_valid) chk($sformatf("v%0d_pc", i), W_PC, vecs[i].pc);
            if (vecs[i].e_regwr) begin
                chk($sformatf("v%0d_wd", i), W_WD, vecs[i].e_wd);
                chk($sformatf("v%0d_a3", i), 32'(W_A3), 32'(vecs[i].a3));
            end
        end
        ExcClr = 0;

        // Stall together with Flush gives a bubble
        drive(1, 32'h400, 3'd0, 3'd0, 0, 0, 32'h111, 5'd3, 1, 0, 0);
        tick();
        chk("pre_flush_regwr", 32'(W_RegWr), 1);
        Stall = 1; Flush = 1;
        drive(1, 32'h404, 3'd0, 3'd0, 0, 0, 32'h999, 5'd3, 1, 0, 0);
        tick();
        chk("flush_stall_valid", 32'(W_Valid), 0);
        chk("flush_stall_regwr", 32'(W_RegWr), 0);
        Stall = 0; Flush = 0;

        // Stall alone holds the stage for two cycles
        drive(1, 32'h408, 3'd0, 3'd0, 0, 0, 32'h222, 5'd4, 1, 0, 0);
        tick();
        Stall = 1;
        drive(1, 32'h40C, 3'd0, 3'd0, 0, 0, 32'h333, 5'd6, 1, 1, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall_wd", W_WD, 32'h222);
            chk("stall_a3", 32'(W_A3), 4);
            chk("stall_pc", W_PC, 32'h408);
            chk("stall_regwr", 32'(W_RegWr), 1);
            chk("stall_trap", 32'(Trap), 0);
        end
        Stall = 0;

        // Exception held by stall, ExcClr ignored while stalled, then squash
        drive(1, 32'h500, 3'd0, 3'd0, 0, 0, 0, 5'd2, 1, 0, 1);
        tick();
        chk("exc_hold0", 32'(W_Exc), 1);
        Stall = 1; ExcClr = 1;
        drive(1, 32'h504, 3'd0, 3'd0, 0, 0, 0, 5'd2, 1, 0, 0);
        tick();
        chk("exc_hold1", 32'(W_Exc), 1);
        chk("exc_hold_code", 32'(W_ExcCode), 5);
        chk("exc_hold_trap", 32'(Trap), 1);
        Stall = 0; ExcClr = 0;
        tick();
        chk("exc_once", 32'(W_Exc), 0);
        chk("exc_squash_valid", 32'(W_Valid), 0);
        chk("exc_still_trap", 32'(Trap), 1);

        // Asynchronous reset in TRAP
        #2;
        Reset = 1'b0;
        #1;
        chk("rst_trap_trap", 32'(Trap), 0);
        chk("rst_trap_valid", 32'(W_Valid), 0);
        chk("rst_trap_pc", W_PC, 0);
        chk("rst_trap_a3", 32'(W_A3), 0);
        chk("rst_trap_wd", W_WD, 0);
        tick();
        Reset = 1'b1;
        drive(1, 32'h600, 3'd0, 3'd0, 0, 0, 32'h77, 5'd12, 1, 0, 0);
        tick();
        chk("post_rst_regwr", 32'(W_RegWr), 1);
        chk("post_rst_wd", W_WD, 32'h77);

        // Randomized run against the reference model
        Stall = 0; Flush = 0; ExcClr = 0;
        do_reset();
        m_trap = 0; e_valid = 0; e_regwr = 0; e_exc = 0; e_code = 0;
        e_a3 = 0; e_pc = 0; e_wd = 0;
        for (int n = 0; n < 400; n++) begin
            logic exc;
            logic [31:0] wd;
            Stall  = ($urandom_range(0, 7) == 0);
            Flush  = ($urandom_range(0, 15) == 0);
            ExcClr = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0);
            case (M_WDsel)
                3'd1:    wd = ref_ext(M_LdType, M_A, M_RD);
                3'd2:    wd = M_PC + 32'd8;
                default: wd = M_ALU;
            endcase
            exc = M_Valid && (M_AdEl || M_AdEs);
            if (Flush) begin
                e_valid = 0; e_regwr = 0; e_exc = 0; e_code = 0;
                if (ExcClr) m_trap = 0;
            end else if (!Stall) begin
                if (m_trap) begin
                    e_valid = 0; e_regwr = 0; e_exc = 0; e_code = 0;
                    if (ExcClr) m_trap = 0;
                end else begin
                    e_valid = M_Valid;
                    e_exc   = exc;
                    e_code  = !exc ? 5'd0 : (M_AdEl ? 5'd4 : 5'd5);
                    e_regwr = M_RegWr && M_Valid && !exc && (M_A3 != 0);
                    e_pc = M_PC; e_a3 = M_A3; e_wd = wd;
                    if (exc) m_trap = 1;
                end
            end
            tick();
            chk("rnd_valid", 32'(W_Valid), 32'(e_valid));
            chk("rnd_regwr", 32'(W_RegWr), 32'(e_regwr));
            chk("rnd_exc", 32'(W_Exc), 32'(e_exc));
            chk("rnd_code", 32'(W_ExcCode), 32'(e_code));
            chk("rnd_trap", 32'(Trap), 32'(m_trap));
            if (e_valid) chk("rnd_pc", W_PC, e_pc);
            if (e_regwr) begin
                chk("rnd_wd", W_WD, e_wd);
                chk("rnd_a3", 32'(W_A3), 32'(e_a3));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
